// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    // Bit counter width for a word of the given size.
    function automatic int piso_cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_hold.sv
// One-entry holding register: stages the next word while the shifter is busy.
module piso_hold #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] hold_data,
    output logic             hold_full
);

    logic [WIDTH-1:0] hold_data_q, hold_data_d;
    logic             hold_full_q, hold_full_d;

    always_comb begin
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
        if (clear) begin
            hold_full_d = 1'b0;
        end
        if (load) begin
            hold_data_d = din;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
        end else begin
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign hold_data = hold_data_q;
    assign hold_full = hold_full_q;

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready input and a one-word skid
// register so consecutive words stream out with no idle gap.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             res,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_en,
    output logic             last,
    output logic             busy
);

    localparam int CW = piso_cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    piso_state_t      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] shift_adv;
    logic             out_bit;

    logic             hold_load, hold_clear, hold_full;
    logic [WIDTH-1:0] hold_data;
    logic             accept;

    piso_hold #(.WIDTH(WIDTH)) u_hold (
        .clk       (clk),
        .res       (res),
        .load      (hold_load),
        .clear     (hold_clear),
        .din       (din),
        .hold_data (hold_data),
        .hold_full (hold_full)
    );

    // Ready depends only on registered state and reset, never on din_valid.
    assign din_ready = res && !hold_full;
    assign accept    = din_valid && din_ready;

    always_comb begin
        shift_adv = '0;
        out_bit   = 1'b0;
        if (MSB_FIRST) begin
            shift_adv = {shift_q[WIDTH-2:0], 1'b0};
            out_bit   = shift_q[WIDTH-1];
        end else begin
            shift_adv = {1'b0, shift_q[WIDTH-1:1]};
            out_bit   = shift_q[0];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        hold_load  = 1'b0;
        hold_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d = din;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != CNT_LAST) begin
                    shift_d   = shift_adv;
                    cnt_d     = cnt_q + CW'(1);
                    hold_load = accept;
                end else if (hold_full) begin
                    shift_d    = hold_data;
                    hold_clear = 1'b1;
                    cnt_d      = '0;
                end else if (accept) begin
                    // Skid register empty on the last bit: bypass it.
                    shift_d = din;
                    cnt_d   = '0;
                end else begin
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    assign sout_en = (state_q == SHIFT);
    assign sout    = sout_en && out_bit;
    assign last    = sout_en && (cnt_q == CNT_LAST);
    assign busy    = sout_en || hold_full;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: MSB-first and LSB-first instances plus a SIPO loopback.
module tb_piso_tx;

    logic       clk;
    logic       res;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready, sout, sout_en, last, busy;

    logic [7:0] din_l;
    logic       din_valid_l;
    logic       din_ready_l, sout_l, sout_en_l, last_l, busy_l;

    logic [7:0] sipo;

    int errors;
    int checks;

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk       (clk),
        .res       (res),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .sout      (sout),
        .sout_en   (sout_en),
        .last      (last),
        .busy      (busy)
    );

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk       (clk),
        .res       (res),
        .din       (din_l),
        .din_valid (din_valid_l),
        .din_ready (din_ready_l),
        .sout      (sout_l),
        .sout_en   (sout_en_l),
        .last      (last_l),
        .busy      (busy_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Receiving SIPO register, shifted only on enabled bit cycles.
    always @(posedge clk) begin
        if (sout_en) sipo <= {sipo[6:0], sout};
    end

    task automatic test_reset();
        res = 1'b0; din = 8'h00; din_valid = 1'b0;
        din_l = 8'h00; din_valid_l = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({sout, sout_en, last, busy, din_ready} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_msb: got sout/en/last/busy/rdy=%b want 00000",
                     {sout, sout_en, last, busy, din_ready});
        end
        checks++;
        if ({sout_l, sout_en_l, last_l, busy_l, din_ready_l} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_lsb: got %b want 00000",
                     {sout_l, sout_en_l, last_l, busy_l, din_ready_l});
        end
        res = 1'b1;
        @(negedge clk);
        checks++;
        if ({sout_en, busy, din_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_release: got en/busy/rdy=%b want 001", {sout_en, busy, din_ready});
        end
    endtask

    task automatic test_single();
        logic [7:0] w;
        w = 8'hA5;
        din = w; din_valid = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) din_valid = 1'b0;
            checks++;
            if ({sout, sout_en, last} !== {w[8-c], 1'b1, c == 8}) begin
                errors++;
                $display("FAIL single_bit%0d: got sout/en/last=%b want %b", c,
                         {sout, sout_en, last}, {w[8-c], 1'b1, c == 8});
            end
        end
        @(negedge clk);
        checks++;
        if ({sout_en, busy, last, din_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL single_end: got en/busy/last/rdy=%b want 0001",
                     {sout_en, busy, last, din_ready});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w;
        logic        exp_rdy;
        w = {8'hA5, 8'h3C};
        din = 8'hA5; din_valid = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            exp_rdy = (c == 1) || (c >= 9);
            checks++;
            if ({sout, sout_en, last, din_ready} !== {w[16-c], 1'b1, (c == 8) || (c == 16), exp_rdy}) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got sout/en/last/rdy=%b want %b", c,
                         {sout, sout_en, last, din_ready},
                         {w[16-c], 1'b1, (c == 8) || (c == 16), exp_rdy});
            end
            if (c == 1) din = 8'h3C;
            if (c == 2) din_valid = 1'b0;
        end
        @(negedge clk);
        checks++;
        if ({sout_en, busy} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_end: got en/busy=%b want 00", {sout_en, busy});
        end
    endtask

    task automatic test_three_words();
        logic [23:0] w;
        logic        exp_rdy;
        logic        exp_last;
        w = {8'hA5, 8'h3C, 8'hC3};
        din = 8'hA5; din_valid = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            exp_rdy  = (c == 1) || (c == 9) || (c >= 17);
            exp_last = (c == 8) || (c == 16) || (c == 24);
            checks++;
            if ({sout, sout_en, last, din_ready} !== {w[24-c], 1'b1, exp_last, exp_rdy}) begin
                errors++;
                $display("FAIL three_cycle%0d: got sout/en/last/rdy=%b want %b", c,
                         {sout, sout_en, last, din_ready}, {w[24-c], 1'b1, exp_last, exp_rdy});
            end
            if (c == 1) din = 8'h3C;
            if (c == 2) din = 8'hC3;
            if (c == 10) din_valid = 1'b0;
        end
        @(negedge clk);
        checks++;
        if ({sout_en, busy} !== 2'b00) begin
            errors++;
            $display("FAIL three_end: got en/busy=%b want 00", {sout_en, busy});
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] w;
        din = 8'hFF; din_valid = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if ({sout, sout_en} !== 2'b11) begin
                errors++;
                $display("FAIL midrst_bit%0d: got sout/en=%b want 11", c, {sout, sout_en});
            end
            if (c == 1) din = 8'h5A;
            if (c == 2) din_valid = 1'b0;
        end
        res = 1'b0;
        @(negedge clk);
        checks++;
        if ({sout, sout_en, busy, din_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_cleared: got sout/en/busy/rdy=%b want 0000",
                     {sout, sout_en, busy, din_ready});
        end
        res = 1'b1;
        w = 8'h0F;
        din = w; din_valid = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) din_valid = 1'b0;
            checks++;
            if ({sout, sout_en, last} !== {w[8-c], 1'b1, c == 8}) begin
                errors++;
                $display("FAIL midrst_new_bit%0d: got sout/en/last=%b want %b", c,
                         {sout, sout_en, last}, {w[8-c], 1'b1, c == 8});
            end
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({sout_en, busy} !== 2'b00) begin
                errors++;
                $display("FAIL midrst_no_held%0d: got en/busy=%b want 00", c, {sout_en, busy});
            end
        end
    endtask

    task automatic test_lsb_first();
        din_l = 8'h01; din_valid_l = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) din_valid_l = 1'b0;
            checks++;
            if ({sout_l, sout_en_l, last_l} !== {c == 1, 1'b1, c == 8}) begin
                errors++;
                $display("FAIL lsb_bit%0d: got sout/en/last=%b want %b", c,
                         {sout_l, sout_en_l, last_l}, {c == 1, 1'b1, c == 8});
            end
        end
        @(negedge clk);
        checks++;
        if ({sout_en_l, busy_l} !== 2'b00) begin
            errors++;
            $display("FAIL lsb_end: got en/busy=%b want 00", {sout_en_l, busy_l});
        end
    endtask

    task automatic test_loopback();
        logic [7:0] lw [4];
        lw = '{8'h00, 8'hFF, 8'hA5, 8'h81};
        for (int i = 0; i < 4; i++) begin
            din = lw[i]; din_valid = 1'b1;
            @(negedge clk);
            din_valid = 1'b0;
            repeat (8) @(negedge clk);
            checks++;
            if (sipo !== lw[i]) begin
                errors++;
                $display("FAIL loopback_%0d: got sipo=%h want %h", i, sipo, lw[i]);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_three_words();
        test_reset_mid();
        test_lsb_first();
        test_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
